fwd_operand_unit: RTL and testbench

Consumes the per-operand dependency codes produced in ID for rs and rt and turns them into operand values. It selects each rs/rt operand from the register file or a forwarding source, stalls ID while load data is not yet usable, and registers the resolved operands into the ID/EX boundary. It sits between the ID-stage dependency logic and the EX-stage operand inputs, and owns load-use stall timing and stall statistics.

---
 rtl/fwd_operand_unit.sv | 170 +++++++++++++++++
 tb/tb_fwd_operand_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_operand_unit.sv
// fwd_operand_unit
// Resolves the rs/rt operands for the instruction in ID from the register
// file or a forwarding source, stalls ID while load data is not usable yet,
// and registers the resolved operands into the ID/EX boundary.
// Optional statistics counters are built only when FWD_STAT_EN is defined;
// otherwise stall_count and fwd_count are tied to zero.
//
// Handshake: an instruction in ID is accepted into EX on a rising edge when
// valid_inst_ID=1, flush=0 and stall_ID=0; that edge loads valid_EX=1 and
// both operands. Any other edge inserts a bubble (valid_EX=0) and leaves the
// operand registers unchanged.
module fwd_operand_unit #(
   parameter int WORD_SIZE = 16,
   parameter int CODE_SIZE = 6,
   parameter int MAX_WAIT  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CODE_SIZE-1:0] dep_code_rs,
   input  logic [CODE_SIZE-1:0] dep_code_rt,
   input  logic                 valid_inst_ID,
   input  logic                 flush,
   input  logic [WORD_SIZE-1:0] rs_data_ID,
   input  logic [WORD_SIZE-1:0] rt_data_ID,
   input  logic [WORD_SIZE-1:0] alu_result_EX,
   input  logic [WORD_SIZE-1:0] alu_result_MEM,
   input  logic [WORD_SIZE-1:0] mem_rdata_MEM,
   input  logic                 mem_rdata_valid,
   input  logic [WORD_SIZE-1:0] wb_data_WB,
   output logic                 stall_ID,
   output logic [WORD_SIZE-1:0] rs_val_EX,
   output logic [WORD_SIZE-1:0] rt_val_EX,
   output logic                 valid_EX,
   output logic                 load_timeout,
   output logic                 dep_err,
   output logic [15:0]          stall_count,
   output logic [15:0]          fwd_count,
   output logic                 fsm_state
);

   localparam logic [CODE_SIZE-1:0] CODE_NONE     = CODE_SIZE'(0);
   localparam logic [CODE_SIZE-1:0] CODE_ALU_EX   = CODE_SIZE'(1);
   localparam logic [CODE_SIZE-1:0] CODE_ALU_MEM  = CODE_SIZE'(2);
   localparam logic [CODE_SIZE-1:0] CODE_LOAD_EX  = CODE_SIZE'(3);
   localparam logic [CODE_SIZE-1:0] CODE_LOAD_MEM = CODE_SIZE'(4);
   localparam logic [CODE_SIZE-1:0] CODE_WB       = CODE_SIZE'(5);

   localparam logic [0:0] ST_RUN       = 1'b0;
   localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   // Resolution result for one operand: {needs_stall, forwarded, illegal, data}
   typedef struct packed {
      logic                 need;
      logic                 fwd;
      logic                 bad;
      logic [WORD_SIZE-1:0] data;
   } res_t;

   function automatic res_t resolve(input logic [CODE_SIZE-1:0] code,
                                    input logic [WORD_SIZE-1:0] reg_data);
      res_t r;
      r.need = 1'b0;
      r.fwd  = 1'b0;
      r.bad  = 1'b0;
      r.data = reg_data;
      case (code)
         CODE_NONE:    ;
         CODE_ALU_EX:  begin r.data = alu_result_EX;  r.fwd = 1'b1; end
         CODE_ALU_MEM: begin r.data = alu_result_MEM; r.fwd = 1'b1; end
         CODE_WB:      begin r.data = wb_data_WB;     r.fwd = 1'b1; end
         CODE_LOAD_EX: r.need = 1'b1;
         CODE_LOAD_MEM: begin
            r.fwd = 1'b1;
            if (mem_rdata_valid) r.data = mem_rdata_MEM;
            else                 r.need = 1'b1;
         end
         // Unknown codes fall back to register data and are flagged.
         default:      r.bad = 1'b1;
      endcase
      return r;
   endfunction

   res_t       rs_res;
   res_t       rt_res;
   logic       issue;
   logic [0:0] state;
   logic [0:0] state_next;
   logic [3:0] wait_cnt;
   logic [3:0] wait_cnt_next;

   // Operand resolution and the combinational stall / issue decisions
   always_comb begin
      rs_res   = resolve(dep_code_rs, rs_data_ID);
      rt_res   = resolve(dep_code_rt, rt_data_ID);
      stall_ID = ~reset & valid_inst_ID & ~flush & (rs_res.need | rt_res.need);
      issue    = valid_inst_ID & ~flush & ~stall_ID;
   end

   // Next state and wait counter; flush always returns the FSM to RUN
   always_comb begin
      state_next    = state;
      wait_cnt_next = 4'd0;
      case (state)
         ST_RUN: begin
            if (stall_ID) state_next = ST_WAIT_LOAD;
         end
         default: begin
            if (flush) begin
               state_next = ST_RUN;
            end else begin
               if (!stall_ID) state_next = ST_RUN;
               wait_cnt_next = (wait_cnt >= WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + 4'd1;
            end
         end
      endcase
   end

   assign fsm_state = state;

   // FSM, wait counter and the sticky status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_RUN;
         wait_cnt     <= 4'd0;
         load_timeout <= 1'b0;
         dep_err      <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (wait_cnt_next == WAIT_LIMIT) load_timeout <= 1'b1;
         if (valid_inst_ID && (rs_res.bad || rt_res.bad)) dep_err <= 1'b1;
      end
   end

   // ID/EX boundary: load on accepted issue, bubble otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_EX  <= 1'b0;
         rs_val_EX <= '0;
         rt_val_EX <= '0;
      end else if (issue) begin
         valid_EX  <= 1'b1;
         rs_val_EX <= rs_res.data;
         rt_val_EX <= rt_res.data;
      end else begin
         valid_EX  <= 1'b0;
      end
   end

`ifdef FWD_STAT_EN
   // Saturating stall-cycle and forwarded-issue counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= 16'd0;
         fwd_count   <= 16'd0;
      end else begin
         if (stall_ID && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
         if (issue && (rs_res.fwd || rt_res.fwd) && fwd_count != 16'hFFFF)
            fwd_count <= fwd_count + 16'd1;
      end
   end
`else
   assign stall_count = 16'd0;
   assign fwd_count   = 16'd0;
`endif

endmodule

// File: tb/tb_fwd_operand_unit.sv
// Testbench for fwd_operand_unit: directed vectors, per-cycle expected
// {valid_EX, rs_val_EX, rt_val_EX} pushed by the driver and checked by a
// separate monitor after each rising edge.
module tb_fwd_operand_unit;

   localparam int W  = 16;
   localparam int CW = 6;

   logic          clk;
   logic          reset;
   logic [CW-1:0] dep_code_rs;
   logic [CW-1:0] dep_code_rt;
   logic          valid_inst_ID;
   logic          flush;
   logic [W-1:0]  rs_data_ID;
   logic [W-1:0]  rt_data_ID;
   logic [W-1:0]  alu_result_EX;
   logic [W-1:0]  alu_result_MEM;
   logic [W-1:0]  mem_rdata_MEM;
   logic          mem_rdata_valid;
   logic [W-1:0]  wb_data_WB;
   logic          stall_ID;
   logic [W-1:0]  rs_val_EX;
   logic [W-1:0]  rt_val_EX;
   logic          valid_EX;
   logic          load_timeout;
   logic          dep_err;
   logic [15:0]   stall_count;
   logic [15:0]   fwd_count;
   logic          fsm_state;

   int tests;
   int fails;
   logic [2*W:0] exp_q[$];

   fwd_operand_unit #(.WORD_SIZE(W), .CODE_SIZE(CW), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .dep_code_rs(dep_code_rs), .dep_code_rt(dep_code_rt),
      .valid_inst_ID(valid_inst_ID), .flush(flush),
      .rs_data_ID(rs_data_ID), .rt_data_ID(rt_data_ID),
      .alu_result_EX(alu_result_EX), .alu_result_MEM(alu_result_MEM),
      .mem_rdata_MEM(mem_rdata_MEM), .mem_rdata_valid(mem_rdata_valid),
      .wb_data_WB(wb_data_WB),
      .stall_ID(stall_ID), .rs_val_EX(rs_val_EX), .rt_val_EX(rt_val_EX),
      .valid_EX(valid_EX), .load_timeout(load_timeout), .dep_err(dep_err),
      .stall_count(stall_count), .fwd_count(fwd_count), .fsm_state(fsm_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply one cycle of stimulus, check stall_ID, queue the expected EX
   // register contents, then return shortly after the edge.
   task automatic drive(input string name, input logic [CW-1:0] cr, input logic [CW-1:0] ct,
                        input logic vi, input logic fl, input logic mv, input logic exp_stall,
                        input logic exp_v, input logic [W-1:0] exp_rs, input logic [W-1:0] exp_rt);
      @(negedge clk);
      dep_code_rs     = cr;
      dep_code_rt     = ct;
      valid_inst_ID   = vi;
      flush           = fl;
      mem_rdata_valid = mv;
      #1;
      check({name, " stall_ID"}, {31'd0, stall_ID}, {31'd0, exp_stall});
      exp_q.push_back({exp_v, exp_rs, exp_rt});
      @(posedge clk);
      #2;
   endtask

   // monitor / scoreboard
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [2*W:0] e;
         e = exp_q.pop_front();
         tests++;
         if ({valid_EX, rs_val_EX, rt_val_EX} !== e) begin
            fails++;
            $display("FAIL ex_regs: got v=%b rs=%h rt=%h expected v=%b rs=%h rt=%h",
                     valid_EX, rs_val_EX, rt_val_EX, e[2*W], e[2*W-1:W], e[W-1:0]);
         end
      end
   end

   logic [15:0] stat1, stat3, stat4, stat6, stat7;

   initial begin
      tests = 0;
      fails = 0;
`ifdef FWD_STAT_EN
      stat1 = 16'd1; stat3 = 16'd3; stat4 = 16'd4; stat6 = 16'd6; stat7 = 16'd7;
`else
      stat1 = 16'd0; stat3 = 16'd0; stat4 = 16'd0; stat6 = 16'd0; stat7 = 16'd0;
`endif
      reset = 1'b1;
      dep_code_rs = '0; dep_code_rt = '0; valid_inst_ID = 1'b0; flush = 1'b0;
      rs_data_ID = 16'h1111; rt_data_ID = 16'h0005;
      alu_result_EX = 16'h1234; alu_result_MEM = 16'h5678;
      mem_rdata_MEM = 16'hBEEF; mem_rdata_valid = 1'b0; wb_data_WB = 16'h9ABC;
      repeat (2) @(posedge clk);
      #1;
      check("rst valid_EX", {31'd0, valid_EX}, 32'd0);
      check("rst rs_val", {16'd0, rs_val_EX}, 32'd0);
      check("rst stall_ID", {31'd0, stall_ID}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // forwarding paths
      drive("alu_ex fwd", 6'd1, 6'd0, 1, 0, 0, 0, 1, 16'h1234, 16'h0005);
      check("fwd_count a", {16'd0, fwd_count}, {16'd0, stat1});
      rt_data_ID = 16'h2222;
      drive("mem/wb fwd", 6'd2, 6'd5, 1, 0, 0, 0, 1, 16'h5678, 16'h9ABC);

      // load-use: code 3 then code 4 with data valid
      drive("load ex", 6'd0, 6'd3, 1, 0, 0, 1, 0, 16'h5678, 16'h9ABC);
      check("state wait", {31'd0, fsm_state}, 32'd1);
      rs_data_ID = 16'h0007;
      drive("load mem", 6'd0, 6'd4, 1, 0, 1, 0, 1, 16'h0007, 16'hBEEF);
      check("stall_count 1", {16'd0, stall_count}, {16'd0, stat1});
      check("fwd_count b", {16'd0, fwd_count}, {16'd0, stat3});
      check("no timeout", {31'd0, load_timeout}, 32'd0);

      // long load wait: 5 stall cycles, timeout after the 4th WAIT_LOAD cycle
      for (int i = 0; i < 5; i++) begin
         drive("load wait", 6'd4, 6'd0, 1, 0, 0, 1, 0, 16'h0007, 16'hBEEF);
         if (i == 3) check("timeout early", {31'd0, load_timeout}, 32'd0);
      end
      check("timeout set", {31'd0, load_timeout}, 32'd1);
      mem_rdata_MEM = 16'hCAFE;
      drive("load done", 6'd4, 6'd0, 1, 0, 1, 0, 1, 16'hCAFE, 16'h2222);
      check("timeout sticky", {31'd0, load_timeout}, 32'd1);
      check("stall_count 6", {16'd0, stall_count}, {16'd0, stat6});
      check("fwd_count c", {16'd0, fwd_count}, {16'd0, stat4});

      // flush over stall
      drive("pre flush", 6'd3, 6'd0, 1, 0, 0, 1, 0, 16'hCAFE, 16'h2222);
      drive("flush", 6'd3, 6'd0, 1, 1, 0, 0, 0, 16'hCAFE, 16'h2222);
      check("state run", {31'd0, fsm_state}, 32'd0);
      rs_data_ID = 16'h1111;
      drive("after flush", 6'd0, 6'd0, 1, 0, 0, 0, 1, 16'h1111, 16'h2222);

      // no instruction: bubble, no stall
      drive("invalid", 6'd3, 6'd0, 0, 0, 0, 0, 0, 16'h1111, 16'h2222);

      // illegal code
      rs_data_ID = 16'h00AA;
      check("dep_err clr", {31'd0, dep_err}, 32'd0);
      drive("illegal", 6'd7, 6'd0, 1, 0, 0, 0, 1, 16'h00AA, 16'h2222);
      check("dep_err set", {31'd0, dep_err}, 32'd1);
      drive("legal", 6'd0, 6'd0, 1, 0, 0, 0, 1, 16'h00AA, 16'h2222);
      check("dep_err sticky", {31'd0, dep_err}, 32'd1);
      check("stall_count 7", {16'd0, stall_count}, {16'd0, stat7});
      check("fwd_count d", {16'd0, fwd_count}, {16'd0, stat4});

      // reset asserted mid-WAIT_LOAD
      drive("stall a", 6'd3, 6'd0, 1, 0, 0, 1, 0, 16'h00AA, 16'h2222);
      drive("stall b", 6'd4, 6'd0, 1, 0, 0, 1, 0, 16'h00AA, 16'h2222);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("arst stall_ID", {31'd0, stall_ID}, 32'd0);
      check("arst rs", {16'd0, rs_val_EX}, 32'd0);
      check("arst rt", {16'd0, rt_val_EX}, 32'd0);
      check("arst timeout", {31'd0, load_timeout}, 32'd0);
      check("arst dep_err", {31'd0, dep_err}, 32'd0);
      check("arst state", {31'd0, fsm_state}, 32'd0);
      check("arst stall_count", {16'd0, stall_count}, 32'd0);
      check("arst valid", {31'd0, valid_EX}, 32'd0);
      dep_code_rs = 6'd0;
      @(negedge clk);
      reset = 1'b0;
      drive("post reset", 6'd0, 6'd0, 1, 0, 0, 0, 1, 16'h00AA, 16'h2222);
      check("post reset state", {31'd0, fsm_state}, 32'd0);

      @(negedge clk);
      check("queue drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
